// File: rtl/snoop_mem_responder_if.sv
// Snooping CDB memory-responder bundle: request/snoop inputs
// from the bus, reply/status outputs back to the bus.
interface snoop_mem_responder_if #(
  parameter int ADDR_W = 4
);
  logic [21:0]       cdbIn;
  logic              cdbValid;
  logic [ADDR_W-1:0] addr;
  logic              dataWB;
  logic              abortMem;
  logic [15:0]       wbData;
  logic [21:0]       cdbOut;
  logic              respValid;
  logic              busy;
  logic              dropped;

  modport master (
    output cdbIn, cdbValid, addr,
    output dataWB, abortMem, wbData,
    input  cdbOut, respValid, busy, dropped
  );

  modport slave (
    input  cdbIn, cdbValid, addr,
    input  dataWB, abortMem, wbData,
    output cdbOut, respValid, busy, dropped
  );
endinterface

// File: rtl/snoop_mem_responder.sv
// Memory agent on the snooping CDB: serves read/write misses,
// absorbs write-backs, replies {010000,data}. Ports: clock, reset_n, bus.
module snoop_mem_responder #(
  parameter int ADDR_W    = 4,
  parameter int SNOOP_CYC = 1,
  parameter int MEM_LAT   = 2
) (
  input logic clock,
  input logic reset_n,
  snoop_mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int SW = $clog2(SNOOP_CYC + 1);
  localparam int MW = $clog2(MEM_LAT + 1);
  localparam logic [SW-1:0] SLAST = SW'(SNOOP_CYC - 1);
  localparam logic [MW-1:0] MLAST = MW'(MEM_LAT - 1);
  localparam logic [5:0] RESP = 6'b010000;

  typedef enum logic [2:0] {
    IDLE, SNOOP, WB, MEMRD, RESPOND
  } state_t;

  state_t state_q, state_d;

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] addr_l;
  logic [15:0]       wbd_q;
  logic              wb_q, ab_q;
  logic [SW-1:0]     scnt_q;
  logic [MW-1:0]     mcnt_q;
  logic [21:0]       cdb_q;
  logic              drop_q;
  logic              is_miss, is_wb;
  logic              wb_any;

  always_comb begin
    is_miss = 1'b0;
    is_wb   = 1'b0;
    unique case (bus.cdbIn[21:16])
      6'b000001,
      6'b000000: is_miss = 1'b1;
      6'b000010: is_wb   = 1'b1;
      default:   ;
    endcase
  end

  // Include this cycle's flag so the window's last cycle counts.
  assign wb_any = wb_q | bus.dataWB;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cdbValid && is_miss) state_d = SNOOP;
      end
      SNOOP: begin
        if (scnt_q == SLAST)
          state_d = wb_any ? WB : MEMRD;
      end
      WB: begin
        state_d = ab_q ? RESPOND : MEMRD;
      end
      MEMRD: begin
        if (mcnt_q == MLAST) state_d = RESPOND;
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      addr_l <= '0;
      wbd_q  <= '0;
      wb_q   <= 1'b0;
      ab_q   <= 1'b0;
      scnt_q <= '0;
      mcnt_q <= '0;
      cdb_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= bus.cdbValid && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (bus.cdbValid && is_miss) begin
            addr_l <= bus.addr;
            wb_q   <= 1'b0;
            ab_q   <= 1'b0;
            scnt_q <= '0;
          end else if (bus.cdbValid && is_wb) begin
            mem[bus.addr] <= bus.cdbIn[15:0];
          end
        end
        SNOOP: begin
          wb_q <= wb_any;
          ab_q <= ab_q | bus.abortMem;
          if (bus.dataWB && !wb_q) wbd_q <= bus.wbData;
          if (scnt_q != SLAST) scnt_q <= scnt_q + 1'b1;
          mcnt_q <= '0;
        end
        WB: begin
          mem[addr_l] <= wbd_q;
          if (ab_q) cdb_q <= {RESP, wbd_q};
          mcnt_q <= '0;
        end
        MEMRD: begin
          if (mcnt_q == MLAST) cdb_q <= {RESP, mem[addr_l]};
          else                 mcnt_q <= mcnt_q + 1'b1;
        end
        RESPOND: ;
        default: ;
      endcase
    end
  end

  assign bus.cdbOut    = cdb_q;
  assign bus.respValid = (state_q == RESPOND);
  assign bus.busy      = (state_q != IDLE);
  assign bus.dropped   = drop_q;

endmodule
